// File: rtl/uart_seg7_pkg.sv
// Shared types and constants for the thinpad board I/O helper.
//   tx_state_t / rx_state_t : UART transmitter / receiver FSM states
//   SEG_LUT                 : hex digit to active-high segment pattern
//                             (bit 0 = a ... bit 6 = g, bit 7 = dp, dp off)
//   calc_bit_clks()         : clocks per serial bit, rounded to nearest
package uart_seg7_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SEG_LUT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Adding half the baud rate before dividing rounds to the nearest
    // whole clock count instead of truncating.
    function automatic int calc_bit_clks(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// One hex digit to seven-segment decoder, purely combinational.
//   hex : 4-bit digit value
//   seg : active-high segments, bit 0 = a ... bit 6 = g, bit 7 = dp (always 0)
module seg7_hex_decoder
    import uart_seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/uart_seg7_io.sv
// Board-level I/O helper: 8N1 UART receiver, 8N1 UART transmitter and a
// two-digit hex seven-segment decoder, all on one clock.
//   clk, rst           : system clock, synchronous active-high reset
//   rxd                : serial input (asynchronous, idle high)
//   rx_data            : last correctly framed received byte
//   rx_data_ready      : one-cycle pulse when rx_data is updated
//   rx_frame_err       : one-cycle pulse when a stop bit is sampled low
//   tx_start, tx_data  : send request and byte, accepted only when idle
//   txd, tx_busy       : serial output (idle high) and busy flag
//   seg_num            : byte to display; seg_lo / seg_hi are its digits
// BIT_CLKS must come out at 4 or more for the half-bit timing to work.
module uart_seg7_io
    import uart_seg7_pkg::*;
#(
    parameter int CLK_FREQ = 11059200,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       rx_frame_err,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    input  logic [7:0] seg_num,
    output logic [7:0] seg_lo,
    output logic [7:0] seg_hi
);

    localparam int BIT_CLKS  = calc_bit_clks(CLK_FREQ, BAUD);
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_err_wait, rx_err_wait_nxt;
    logic [7:0]       rx_data_nxt;
    logic             rx_ready_nxt, rx_err_nxt;
    logic             rxd_meta, rxd_sync;

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    // Transmitter next state and line outputs. The last stop-bit clock also
    // accepts a pending tx_start so that streamed frames have no idle gap.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        txd          = 1'b1;
        tx_busy      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_busy = 1'b0;
                if (tx_start) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = tx_data;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_start) begin
                        tx_state_nxt = TX_START;
                        tx_shift_nxt = tx_data;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Receiver state register, input synchroniser and registered outputs.
    // The synchroniser resets high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta      <= 1'b1;
            rxd_sync      <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_err_wait   <= 1'b0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rxd_meta      <= rxd;
            rxd_sync      <= rxd_meta;
            rx_state      <= rx_state_nxt;
            rx_cnt        <= rx_cnt_nxt;
            rx_bit        <= rx_bit_nxt;
            rx_shift      <= rx_shift_nxt;
            rx_err_wait   <= rx_err_wait_nxt;
            rx_data       <= rx_data_nxt;
            rx_data_ready <= rx_ready_nxt;
            rx_frame_err  <= rx_err_nxt;
        end
    end

    // Receiver next state. Bits are sampled mid-cell; a bad stop bit parks
    // in RX_STOP (rx_err_wait) until the line returns high, so a held-low
    // line cannot be mistaken for a stream of new start bits.
    always_comb begin
        rx_state_nxt    = rx_state;
        rx_cnt_nxt      = rx_cnt;
        rx_bit_nxt      = rx_bit;
        rx_shift_nxt    = rx_shift;
        rx_err_wait_nxt = rx_err_wait;
        rx_data_nxt     = rx_data;
        rx_ready_nxt    = 1'b0;
        rx_err_nxt      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_sync) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    rx_state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rxd_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_err_wait) begin
                    if (rxd_sync) begin
                        rx_err_wait_nxt = 1'b0;
                        rx_state_nxt    = RX_IDLE;
                    end
                end else if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rxd_sync) begin
                        rx_data_nxt  = rx_shift;
                        rx_ready_nxt = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_err_nxt      = 1'b1;
                        rx_err_wait_nxt = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    seg7_hex_decoder u_seg_lo (
        .hex (seg_num[3:0]),
        .seg (seg_lo)
    );

    seg7_hex_decoder u_seg_hi (
        .hex (seg_num[7:4]),
        .seg (seg_hi)
    );

endmodule

// File: tb/tb_uart_seg7_io.sv
// Self-checking bench for uart_seg7_io: reset state, directed and random
// UART transmit/receive frames, framing error, start glitch, back-to-back
// loopback, mid-frame reset and the segment decoder.
`timescale 1ns/1ps
module tb_uart_seg7_io;

    localparam int BITC = 96;
    localparam int FRAME = 10 * BITC;

    localparam logic [7:0] SEG_REF [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rxd_drv;
    logic       loop_en;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_busy;
    logic [7:0] seg_num;
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int cycle     = 0;

    int         ready_cnt = 0;
    int         err_cnt   = 0;
    int         last_ready_cycle = 0;
    int         last_err_cycle   = 0;
    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_seg7_io #(
        .CLK_FREQ (11059200),
        .BAUD     (115200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .seg_num       (seg_num),
        .seg_lo        (seg_lo),
        .seg_hi        (seg_hi)
    );

    always @(posedge clk) cycle++;

    // Pulse monitor on the falling edge: every high sample is one pulse cycle,
    // so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (rx_data_ready === 1'b1) begin
            ready_cnt++;
            last_ready_cycle = cycle;
            rx_q.push_back(rx_data);
        end
        if (rx_frame_err === 1'b1) begin
            err_cnt++;
            last_err_cycle = cycle;
        end
    end

    // Line level of bit cell idx (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return ((d >> (idx - 1)) & 8'h01) != 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [7:0] data);
        tx_start = start;
        tx_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_seg(input logic [7:0] num);
        seg_num = num;
        #1;
        checkOutput("seg_lo", seg_lo, SEG_REF[num % 16]);
        checkOutput("seg_hi", seg_hi, SEG_REF[num / 16]);
    endtask

    // Sends one frame and checks every clock of it; optionally fires an
    // ignored tx_start with 0xFF at clock 100 of the frame.
    task automatic run_tx_frame(input logic [7:0] d, input bit inject);
        applyStimulus(1'b1, d);
        tick();
        applyStimulus(1'b0, d);
        for (int n = 0; n < FRAME; n++) begin
            checkOutput("tx_bit", txd, frame_bit(d, n / BITC));
            checkOutput("tx_busy", tx_busy, 1);
            if (inject && n == 99) applyStimulus(1'b1, 8'hFF);
            else if (inject && n == 100) applyStimulus(1'b0, 8'hFF);
            tick();
        end
        checkOutput("tx_busy_fall", tx_busy, 0);
        checkOutput("tx_idle_line", txd, 1);
    endtask

    task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit,
                                 output int start_cyc);
        start_cyc = cycle;
        for (int b = 0; b < 10; b++) begin
            rxd_drv = (b == 9) ? stop_bit : frame_bit(d, b);
            repeat (BITC) tick();
        end
        rxd_drv = 1'b1;
    endtask

    // Good frame: exactly one ready pulse, about 9.5 bit times after the edge.
    task automatic check_rx_good(input logic [7:0] d);
        int st, rc0, ec0, lat;
        rc0 = ready_cnt;
        ec0 = err_cnt;
        send_rx_frame(d, 1'b1, st);
        repeat (20) tick();
        lat = last_ready_cycle - st;
        checkOutput("rx_ready_count", ready_cnt - rc0, 1);
        checkOutput("rx_no_err", err_cnt - ec0, 0);
        checkOutput("rx_data", rx_data, d);
        checkOutput("rx_pulse_data", rx_q[rx_q.size() - 1], d);
        checkOutput("rx_latency_ok", (lat >= 910 && lat <= 920), 1);
    endtask

    initial begin
        int         st, rc0, ec0, rq0;
        logic [7:0] held, rnd;

        rst = 1'b1;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        applyStimulus(1'b0, 8'h00);
        seg_num = 8'h00;

        // Reset held for three clocks; the decoder must work regardless.
        repeat (3) tick();
        for (int n = 0; n < 16; n++) check_seg(8'((n << 4) | (15 - n)));
        rst = 1'b0;
        for (int n = 0; n < 16; n++) check_seg(8'((n << 4) | (15 - n)));

        for (int i = 0; i < 200; i++) begin
            checkOutput("rst_txd", txd, 1);
            checkOutput("rst_busy", tx_busy, 0);
            checkOutput("rst_rx_data", rx_data, 8'h00);
            checkOutput("rst_ready", rx_data_ready, 0);
            checkOutput("rst_err", rx_frame_err, 0);
            tick();
        end

        $display("[TB] transmit frames");
        run_tx_frame(8'hA5, 1'b1);
        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            run_tx_frame(8'($urandom_range(0, 255)), 1'b0);
        end
        checkOutput("tx_no_rx_activity", ready_cnt + err_cnt, 0);

        $display("[TB] receive frames");
        check_rx_good(8'h3C);

        rc0 = ready_cnt;
        ec0 = err_cnt;
        send_rx_frame(8'h81, 1'b0, st);
        repeat (200) tick();
        checkOutput("err_count", err_cnt - ec0, 1);
        checkOutput("err_no_ready", ready_cnt - rc0, 0);
        checkOutput("err_rx_data_held", rx_data, 8'h3C);
        checkOutput("err_latency_ok",
                    (last_err_cycle - st >= 910 && last_err_cycle - st <= 920), 1);

        rc0 = ready_cnt;
        ec0 = err_cnt;
        rxd_drv = 1'b0;
        repeat (20) tick();
        rxd_drv = 1'b1;
        repeat (200) tick();
        checkOutput("glitch_no_ready", ready_cnt - rc0, 0);
        checkOutput("glitch_no_err", err_cnt - ec0, 0);
        checkOutput("glitch_rx_data_held", rx_data, 8'h3C);

        for (int i = 0; i < 3; i++) begin
            rnd = 8'($urandom_range(0, 255));
            check_rx_good(rnd);
        end

        $display("[TB] back-to-back loopback");
        loop_en = 1'b1;
        rq0 = rx_q.size();
        rc0 = ready_cnt;
        applyStimulus(1'b1, 8'h00);
        tick();
        applyStimulus(1'b1, 8'hFF);
        for (int n = 0; n < 2 * FRAME; n++) begin
            held = (n < FRAME) ? 8'h00 : 8'hFF;
            checkOutput("b2b_bit", txd, frame_bit(held, (n % FRAME) / BITC));
            checkOutput("b2b_busy", tx_busy, 1);
            if (n == FRAME) applyStimulus(1'b0, 8'hFF);
            tick();
        end
        checkOutput("b2b_busy_fall", tx_busy, 0);
        repeat (100) tick();
        checkOutput("b2b_ready_count", ready_cnt - rc0, 2);
        checkOutput("b2b_first", rx_q[rq0], 8'h00);
        checkOutput("b2b_second", rx_q[rq0 + 1], 8'hFF);
        loop_en = 1'b0;

        $display("[TB] segment decoder");
        check_seg(8'h00);
        check_seg(8'h9A);
        check_seg(8'hEF);
        for (int i = 0; i < 8; i++) check_seg(8'($urandom_range(0, 255)));

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        tick();
        applyStimulus(1'b0, 8'h00);
        repeat (300) tick();
        checkOutput("mid_busy_before", tx_busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_txd", txd, 1);
        checkOutput("mid_rst_busy", tx_busy, 0);
        checkOutput("mid_rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) tick();
        run_tx_frame(8'($urandom_range(0, 255)), 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
